// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg : shared fetch constants and queue entry type | rev 1.0
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam logic [31:0] C_PC_RESET = 32'h0000_3000;
    localparam logic [31:0] C_IM_BASE  = 32'h0000_3000;
    localparam int          C_IM_WORDS = 4096;
    localparam int          C_FQ_DEPTH = 2;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : power-of-two FIFO of fetch entries with flush | rev 1.0
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = C_FQ_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fq_entry_t                wdata_i,
    output fq_entry_t                rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(DEPTH);

    fq_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full queue still accepts a write when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_sequencer : fetch PC, address check and queue toward decode | rev 1.0
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] PC_RESET = C_PC_RESET,
    parameter logic [31:0] IM_BASE  = C_IM_BASE,
    parameter int          IM_WORDS = C_IM_WORDS,
    parameter int          FQ_DEPTH = C_FQ_DEPTH
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_rdata_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_exc_o,
    output logic [31:0] fetch_pc_o
);

    // 33-bit limit so a memory ending at 4 GiB does not wrap the compare.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

    logic [31:0]              fetch_pc_q, fetch_pc_d;
    logic                     halt_q, halt_d;
    logic                     bad_addr;
    logic                     push;
    logic                     pop;
    fq_entry_t                push_entry;
    fq_entry_t                head_entry;
    logic [$clog2(FQ_DEPTH):0] fq_count;
    logic                     fq_empty;
    logic                     fq_full;

    assign bad_addr = (fetch_pc_q[1:0] != 2'b00)
                   || (fetch_pc_q < IM_BASE)
                   || ({1'b0, fetch_pc_q} >= IM_LIMIT);

    assign pop  = !fq_empty && out_ready_i && !redirect_valid_i;
    assign push = !redirect_valid_i && !halt_q && (!fq_full || pop);

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = bad_addr ? C_NOP : im_rdata_i;
    assign push_entry.exc   = bad_addr;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halt_d     = halt_q;
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            halt_d     = 1'b0;
        end else if (push) begin
            if (bad_addr) begin
                halt_d = 1'b1;
            end else begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc_q <= PC_RESET;
            halt_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halt_q     <= halt_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid_i),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (fq_count),
        .empty_o (fq_empty),
        .full_o  (fq_full)
    );

    assign out_valid_o = (fq_count != '0);
    assign out_pc_o    = out_valid_o ? head_entry.pc    : 32'h0;
    assign out_instr_o = out_valid_o ? head_entry.instr : 32'h0;
    assign out_exc_o   = out_valid_o ? head_entry.exc   : 1'b0;

    assign im_addr_o  = fetch_pc_q;
    assign fetch_pc_o = fetch_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : scoreboard bench with a queue-level reference model | rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam logic [31:0] LIMIT  = 32'h0000_7000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_ready = 1'b0;
    logic [31:0] im_addr, im_rdata;
    logic        out_valid, out_exc;
    logic [31:0] out_instr, out_pc, fetch_pc;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] m_pc   = 32'h0000_3000;
    bit          m_halt = 1'b0;
    logic [31:0] im_mem [4096];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .im_addr_o        (im_addr),
        .im_rdata_i       (im_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_instr_o      (out_instr),
        .out_pc_o         (out_pc),
        .out_exc_o        (out_exc),
        .fetch_pc_o       (fetch_pc)
    );

    function automatic bit is_bad(logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a >= LIMIT);
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return im_mem[off[11:0]];
    endfunction

    // Garbage on bad addresses: the design must ignore memory output there.
    assign im_rdata = is_bad(im_addr) ? 32'hDEAD_BEEF : mem_word(im_addr);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: fetch stream as a bounded queue, updated per clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_pc   = BASE;
            m_halt = 1'b0;
        end else begin
            bit bad, do_pop, do_push;
            bad     = is_bad(m_pc);
            do_pop  = (exp_q.size() != 0) && out_ready && !redirect_valid;
            do_push = !redirect_valid && !m_halt && ((exp_q.size() < DEPTH) || do_pop);
            if (redirect_valid) begin
                exp_q.delete();
                m_pc   = redirect_pc;
                m_halt = 1'b0;
            end else begin
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) begin
                    ent_t e;
                    e.pc    = m_pc;
                    e.instr = bad ? 32'h0 : mem_word(m_pc);
                    e.exc   = bad;
                    exp_q.push_back(e);
                    if (bad) m_halt = 1'b1;
                    else     m_pc   = m_pc + 32'd4;
                end
            end
        end
    end

    // Monitor: compares the presented head and PC against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("fetch_pc", fetch_pc, m_pc);
            check("im_addr", im_addr, m_pc);
            if (exp_q.size() != 0) begin
                check("out_pc", out_pc, exp_q[0].pc);
                check("out_instr", out_instr, exp_q[0].instr);
                check("out_exc", 32'(out_exc), 32'(exp_q[0].exc));
            end else begin
                check("idle_pc", out_pc, 32'h0);
                check("idle_instr", out_instr, 32'h0);
                check("idle_exc", 32'(out_exc), 32'h0);
            end
        end
    end

    task automatic cyc(bit rdy, bit rv = 1'b0, logic [31:0] rp = 32'h0);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) im_mem[i] = $urandom;
        im_mem[0] = 32'h2401_0001;
        im_mem[1] = 32'h2402_0002;

        @(posedge clk); #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_pc", fetch_pc, 32'h0000_3000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Back-to-back delivery after reset.
        cyc(1'b1);
        check("first_pc", out_pc, 32'h0000_3000);
        check("first_instr", out_instr, 32'h2401_0001);
        cyc(1'b1);
        check("second_pc", out_pc, 32'h0000_3004);
        check("second_instr", out_instr, 32'h2402_0002);
        cyc(1'b1);

        // Stall until full, then drain in order.
        cyc(1'b0, 1'b1, 32'h0000_3000);
        repeat (5) cyc(1'b0);
        check("stall_fetch_pc", fetch_pc, 32'h0000_3008);
        check("stall_head", out_pc, 32'h0000_3000);
        repeat (3) cyc(1'b1);

        // Redirect while full with ready high: head discarded.
        repeat (3) cyc(1'b0);
        cyc(1'b1, 1'b1, 32'h0000_3100);
        check("redir_flush_valid", 32'(out_valid), 32'h0);
        cyc(1'b1);
        check("redir_target", out_pc, 32'h0000_3100);

        // Misaligned target: single exc entry then halt.
        cyc(1'b1, 1'b1, 32'h0000_3102);
        cyc(1'b1);
        check("misalign_exc", 32'(out_exc), 32'h1);
        repeat (10) cyc(1'b1);
        check("halt_pc", fetch_pc, 32'h0000_3102);
        cyc(1'b1, 1'b1, 32'h0000_3000);
        repeat (3) cyc(1'b1);

        // Last word then past the end of memory.
        cyc(1'b1, 1'b1, 32'h0000_6FFC);
        cyc(1'b1);
        check("last_word_pc", out_pc, 32'h0000_6FFC);
        cyc(1'b1);
        check("end_exc_pc", out_pc, 32'h0000_7000);
        check("end_exc", 32'(out_exc), 32'h1);
        repeat (4) cyc(1'b1);

        // Asynchronous reset between edges with a full queue.
        cyc(1'b0, 1'b1, 32'h0000_3040);
        repeat (3) cyc(1'b0);
        #3 reset = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 32'h0);
        check("async_pc", fetch_pc, 32'h0000_3000);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b1);
        check("restart_pc", out_pc, 32'h0000_3000);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit          rdy, rv;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 7))
                0:       tgt = BASE + 32'($urandom_range(0, 255));
                1:       tgt = $urandom_range(0, 1) ? 32'h0000_6FF8 : 32'h0000_6FFC;
                2:       tgt = 32'h0000_2FFC;
                3:       tgt = 32'hFFFF_FFFC;
                default: tgt = BASE + 32'(4 * $urandom_range(0, 4095));
            endcase
            cyc(rdy, rv, tgt);
        end

        cyc(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
